// File: rtl/room_occupancy_counter_if.sv
// ============================================================================
// Module : room_occupancy_counter_if
// Brief  : Button inputs and occupancy outputs of the room occupancy counter.
// Rev    : 1.0 - initial release
// ============================================================================
`default_nettype none

interface room_occupancy_counter_if;
  logic [2:0] enter;
  logic [2:0] leave;
  logic [2:0] C1;
  logic [2:0] C2;
  logic [2:0] C3;
  logic [4:0] total;
  logic       overflow;
  logic       underflow;

  modport master (
    output enter, leave,
    input  C1, C2, C3, total, overflow, underflow
  );

  modport slave (
    input  enter, leave,
    output C1, C2, C3, total, overflow, underflow
  );
endinterface

`default_nettype wire

// File: rtl/room_occupancy_counter.sv
// ============================================================================
// Module : room_occupancy_counter
// Brief  : Synchronise, debounce and edge-detect six buttons; keep three
//          saturating 3-bit room counts with total and fault pulses.
// Rev    : 1.0 - initial release
// ============================================================================
`default_nettype none

module room_occupancy_counter #(
  parameter int DEBOUNCE_CYCLES = 1000000
) (
  input  wire logic                clock,
  input  wire logic                reset,
  room_occupancy_counter_if.slave  bus
);

  localparam int              CNT_W   = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;
  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(DEBOUNCE_CYCLES - 1);

  // Bits 2:0 are the entry buttons, bits 5:3 the exit buttons.
  logic [5:0] w_raw;
  logic [5:0] r_s1;
  logic [5:0] r_s2;
  logic [5:0] w_db;
  logic [5:0] r_db_d;
  logic [5:0] w_press;
  logic [8:0] w_count;
  logic [2:0] w_ovf;
  logic [2:0] w_unf;
  logic       r_overflow;
  logic       r_underflow;

  assign w_raw = {bus.leave, bus.enter};

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      r_s1   <= '0;
      r_s2   <= '0;
      r_db_d <= '0;
    end else begin
      r_s1   <= w_raw;
      r_s2   <= r_s1;
      r_db_d <= w_db;
    end
  end

  generate
    for (genvar i = 0; i < 6; i++) begin : g_debounce
      logic [CNT_W-1:0] r_cnt;
      logic             r_level;

      // Any sample agreeing with the current level restarts the stability count.
      always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
          r_cnt   <= '0;
          r_level <= 1'b0;
        end else if (r_s2[i] != r_level) begin
          if (r_cnt == CNT_MAX) begin
            r_level <= r_s2[i];
            r_cnt   <= '0;
          end else begin
            r_cnt <= r_cnt + 1'b1;
          end
        end else begin
          r_cnt <= '0;
        end
      end

      assign w_db[i] = r_level;
    end
  endgenerate

  assign w_press = w_db & ~r_db_d;

  generate
    for (genvar r = 0; r < 3; r++) begin : g_room
      logic       w_enter_only;
      logic       w_leave_only;
      logic [2:0] r_value;

      // Simultaneous entry and exit cancel out with no fault.
      assign w_enter_only = w_press[r] & ~w_press[r+3];
      assign w_leave_only = w_press[r+3] & ~w_press[r];
      assign w_ovf[r]     = w_enter_only & (r_value == 3'd7);
      assign w_unf[r]     = w_leave_only & (r_value == 3'd0);

      always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
          r_value <= 3'd0;
        end else if (w_enter_only && (r_value != 3'd7)) begin
          r_value <= r_value + 3'd1;
        end else if (w_leave_only && (r_value != 3'd0)) begin
          r_value <= r_value - 3'd1;
        end
      end

      assign w_count[3*r +: 3] = r_value;
    end
  endgenerate

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      r_overflow  <= 1'b0;
      r_underflow <= 1'b0;
    end else begin
      r_overflow  <= |w_ovf;
      r_underflow <= |w_unf;
    end
  end

  assign bus.C1        = w_count[2:0];
  assign bus.C2        = w_count[5:3];
  assign bus.C3        = w_count[8:6];
  assign bus.total     = {2'b00, w_count[2:0]} + {2'b00, w_count[5:3]} + {2'b00, w_count[8:6]};
  assign bus.overflow  = r_overflow;
  assign bus.underflow = r_underflow;

endmodule

`default_nettype wire

// File: doc/room_occupancy_counter.md
Name: room_occupancy_counter

Overview:
Produces the per-room occupancy counts consumed by the room-balance checker. Takes six raw push-button/sensor inputs (one entry and one exit per room), synchronises and debounces each one, and edge-detects the press. Each room's 3-bit count is then incremented or decremented with saturation. Outputs C1/C2/C3 feed the balance-rule logic directly; total and the fault pulses feed the seven-segment and LED display logic.

Parameters:
DEBOUNCE_CYCLES, 1000000, consecutive stable cycles required before a debounced level changes (10 ms at 100 MHz); legal range is 1 or more.

Ports:
clock  input  1  system clock, all logic on the rising edge
reset  input  1  asynchronous, active-high reset
enter  input  3  raw entry buttons; bit0 = room 1, bit1 = room 2, bit2 = room 3; asynchronous and bouncy
leave  input  3  raw exit buttons; same bit mapping as enter
C1  output  3  room 1 occupancy, range 0..7
C2  output  3  room 2 occupancy, range 0..7
C3  output  3  room 3 occupancy, range 0..7
total  output  5  C1+C2+C3, range 0..21
overflow  output  1  one-cycle pulse: an entry was rejected because the room was at 7
underflow  output  1  one-cycle pulse: an exit was rejected because the room was at 0

Behaviour:
- Reset (asynchronous assert, released on a clock edge):
  - C1, C2, C3 = 0; total = 0; overflow = underflow = 0.
  - All sync flops, debounced levels, delayed levels and debounce counters = 0.
- Synchroniser:
  - Each of the 6 inputs passes through 2 flops (s1, s2) before any other use.
- Debouncer, one per input:
  - Holds registered level db and counter cnt, wide enough to reach DEBOUNCE_CYCLES-1.
  - Each edge with s2 != db: if cnt == DEBOUNCE_CYCLES-1, then db <= s2 and cnt <= 0; otherwise cnt <= cnt+1.
  - Each edge with s2 == db: cnt <= 0. Any glitch shorter than DEBOUNCE_CYCLES therefore restarts the count.
  - Release (1 -> 0) is debounced identically.
- Edge detect:
  - db_d <= db every edge.
  - press = db & ~db_d, combinational.
  - Exactly one press per debounced rising level; holding the button produces no further presses.
- Count update, per room, applied on the edge where press is high:
  - Entry only, count < 7: count + 1.
  - Entry only, count = 7: count holds; overflow = 1 for one cycle.
  - Exit only, count > 0: count - 1.
  - Exit only, count = 0: count holds; underflow = 1 for one cycle.
  - Entry and exit presses in the same cycle: no change, no fault pulse.
  - Rooms are independent. Simultaneous events in different rooms all apply in the same cycle.
  - overflow and underflow are the OR across the three rooms, registered on the same edge as the counts.
- Latency:
  - With a clean raw edge first sampled at edge 1, db changes at edge DEBOUNCE_CYCLES+2.
  - The count and fault pulse update at edge DEBOUNCE_CYCLES+3.
- total:
  - Combinational 5-bit sum of the registered C1+C2+C3, so it is valid in the same cycle as the counts.
- Reset mid-debounce or mid-press:
  - Everything clears immediately.
  - A button still held after reset releases is debounced afresh from db = 0 and produces one new press.

Test Plan:
- DEBOUNCE_CYCLES=4, reset, then hold enter[0] high for 20 cycles -> C1 goes 0 -> 1 at edge 7 after the first sample, stays 1; total = 1; no fault pulses.
- enter[1] bounces (high 2 cycles, low 1, high 2, low 1), then holds high 10 cycles -> exactly one increment, C2 = 1; glitches alone leave C2 = 0.
- 9 clean presses on enter[2] -> C3 climbs to 7; presses 8 and 9 each give a single-cycle overflow pulse with C3 held at 7.
- leave[0] press with C1 = 0 -> C1 stays 0 and underflow pulses once; then enter[0] and leave[0] pressed identically in the same cycles with C1 = 3 -> C1 stays 3, no pulses.
- C1 = 2, C2 = 5, C3 = 7 -> total = 14; simultaneous entry on room 1 and exit on room 2 -> C1 = 3, C2 = 4, total = 14.
- Assert reset for 1 cycle mid-debounce of a held enter[0] with C1 = 4 -> all outputs 0 immediately; after release, C1 becomes 1 after DEBOUNCE_CYCLES+3 edges.
